// File: rtl/mxn_rr_reg_pkg.sv
// Shared constants and helpers for the parametrised selector/arbiter family.
package mxn_rr_reg_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Width of an index field able to address n channels (at least one bit).
   function automatic int unsigned sel_width(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/mxn_rr_reg_rr_pick.sv
// Rotating-priority search: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int unsigned N    = 8,
   parameter int unsigned SELW = 3
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            found,
   output logic [SELW-1:0] idx
);

   // Pick the requester with the smallest rotated distance from ptr.
   always_comb begin
      int unsigned best_d;
      int unsigned d;
      found  = 1'b0;
      idx    = '0;
      best_d = N;
      d      = 0;
      for (int unsigned j = 0; j < N; j++) begin
         d = (j >= 32'(ptr)) ? (j - 32'(ptr)) : (j + N - 32'(ptr));
         if (req[j] && (d < best_d)) begin
            best_d = d;
            idx    = SELW'(j);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mxn_rr_reg.sv
// N-to-1 registered selector with fixed-select / round-robin modes and valid/ready output.
module mxn_rr_reg
   import mxn_rr_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 8,
   parameter int unsigned SELW  = sel_width(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] i_data,
   input  logic [N-1:0]       i_valid,
   output logic [N-1:0]       o_ack,
   input  logic               i_mode,
   input  logic [SELW-1:0]    i_sel,
   output logic [WIDTH-1:0]   o_data,
   output logic [SELW-1:0]    o_sel,
   output logic               o_valid,
   input  logic               i_ready
);

   logic [SELW-1:0]  ptr;
   logic             load_c;
   logic             rr_found_c;
   logic [SELW-1:0]  rr_idx_c;
   logic             fixed_ok_c;
   logic [SELW-1:0]  cand_c;
   logic             grant_c;
   logic [WIDTH-1:0] cand_data_c;

   rr_pick #(
      .N    (N),
      .SELW (SELW)
   ) u_rr_pick (
      .req   (i_valid),
      .ptr   (ptr),
      .found (rr_found_c),
      .idx   (rr_idx_c)
   );

   // Candidate choice, grant decision, one-hot ack and captured channel data.
   always_comb begin
      load_c      = !o_valid || i_ready;
      fixed_ok_c  = 1'b0;
      cand_data_c = '0;
      o_ack       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (i_sel == SELW'(k)) fixed_ok_c = i_valid[k];
      end
      cand_c  = (i_mode == MODE_RR) ? rr_idx_c : i_sel;
      grant_c = !reset && load_c && ((i_mode == MODE_RR) ? rr_found_c : fixed_ok_c);
      for (int unsigned k = 0; k < N; k++) begin
         if (cand_c == SELW'(k)) begin
            cand_data_c = i_data[k*WIDTH +: WIDTH];
            o_ack[k]    = grant_c;
         end
      end
   end

   // Output register and round-robin pointer; everything holds while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sel   <= '0;
         ptr     <= '0;
      end else if (load_c) begin
         o_valid <= grant_c;
         if (grant_c) begin
            o_data <= cand_data_c;
            o_sel  <= cand_c;
            if (i_mode == MODE_RR) begin
               ptr <= (cand_c == SELW'(N - 1)) ? '0 : cand_c + SELW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mxn_rr_reg.sv
// Scoreboard bench for mxn_rr_reg: 8x32 instance and a non-power-of-2 5x16 instance.
module tb_mxn_rr_reg;
   import mxn_rr_reg_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  sel;
   } beat_t;

   logic clk = 1'b0;
   logic reset;

   logic [255:0] a_data;
   logic [7:0]   a_valid, a_ack;
   logic         a_mode, a_ovalid, a_ready;
   logic [2:0]   a_sel, a_osel;
   logic [31:0]  a_odata;

   logic [79:0]  b_data;
   logic [4:0]   b_valid, b_ack;
   logic         b_mode, b_ovalid, b_ready;
   logic [2:0]   b_sel, b_osel;
   logic [15:0]  b_odata;

   beat_t qa[$];
   beat_t qb[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mxn_rr_reg #(.WIDTH(32), .N(8)) dut_a (
      .clk(clk), .reset(reset), .i_data(a_data), .i_valid(a_valid), .o_ack(a_ack),
      .i_mode(a_mode), .i_sel(a_sel), .o_data(a_odata), .o_sel(a_osel),
      .o_valid(a_ovalid), .i_ready(a_ready)
   );

   mxn_rr_reg #(.WIDTH(16), .N(5)) dut_b (
      .clk(clk), .reset(reset), .i_data(b_data), .i_valid(b_valid), .o_ack(b_ack),
      .i_mode(b_mode), .i_sel(b_sel), .o_data(b_odata), .o_sel(b_osel),
      .o_valid(b_ovalid), .i_ready(b_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: every accepted beat is popped from its scoreboard and compared.
   always @(negedge clk) begin
      if (a_ovalid === 1'b1 && a_ready === 1'b1) begin
         if (qa.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected_beat: got sel %0d expected none", a_osel);
         end else begin
            beat_t e;
            e = qa.pop_front();
            chk("a_data", 64'(a_odata), 64'(e.data));
            chk("a_sel", 64'(a_osel), 64'(e.sel));
         end
      end
   end

   always @(negedge clk) begin
      if (b_ovalid === 1'b1 && b_ready === 1'b1) begin
         if (qb.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected_beat: got sel %0d expected none", b_osel);
         end else begin
            beat_t e;
            e = qb.pop_front();
            chk("b_data", 64'(b_odata), 64'(e.data));
            chk("b_sel", 64'(b_osel), 64'(e.sel));
         end
      end
   end

   // One cycle on instance A: drive, check ack mid-cycle, queue the expected beat.
   task automatic step_a(input logic [7:0] v, input logic m, input logic [2:0] s,
                         input logic r, input logic [7:0] exp_ack);
      a_valid = v; a_mode = m; a_sel = s; a_ready = r;
      @(negedge clk);
      chk("a_ack", 64'(a_ack), 64'(exp_ack));
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         if (exp_ack[k]) qa.push_back('{data: 32'hA000_0000 + 32'(k), sel: 3'(k)});
      end
   endtask

   task automatic step_b(input logic [4:0] v, input logic m, input logic [2:0] s,
                         input logic r, input logic [4:0] exp_ack);
      b_valid = v; b_mode = m; b_sel = s; b_ready = r;
      @(negedge clk);
      chk("b_ack", 64'(b_ack), 64'(exp_ack));
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         if (exp_ack[k]) qb.push_back('{data: 32'h0000_B000 + 32'(k), sel: 3'(k)});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 8; k++) a_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      for (int k = 0; k < 5; k++) b_data[k*16 +: 16] = 16'hB000 + 16'(k);
      b_valid = '0; b_mode = MODE_FIXED; b_sel = '0; b_ready = 1'b1;
      reset = 1'b1;

      // Reset with every channel requesting: no ack, outputs cleared.
      step_a(8'hFF, MODE_RR, 3'd0, 1'b1, 8'h00);
      step_a(8'hFF, MODE_RR, 3'd0, 1'b1, 8'h00);
      chk("a_rst_valid", 64'(a_ovalid), 64'd0);
      chk("a_rst_data", 64'(a_odata), 64'd0);
      chk("a_rst_sel", 64'(a_osel), 64'd0);
      reset = 1'b0;

      // Round-robin fairness over all channels: 0..7,0,1.
      for (int i = 0; i < 10; i++) step_a(8'hFF, MODE_RR, 3'd0, 1'b1, 8'(1 << (i % 8)));

      // Fixed select of channel 5, then channel 5 idle -> bubble, data/sel hold.
      step_a(8'hFF, MODE_FIXED, 3'd5, 1'b1, 8'h20);
      step_a(8'hDF, MODE_FIXED, 3'd5, 1'b1, 8'h00);
      chk("a_nogrant_valid", 64'(a_ovalid), 64'd0);
      chk("a_nogrant_data", 64'(a_odata), 64'hA000_0005);
      chk("a_nogrant_sel", 64'(a_osel), 64'd5);

      // Sparse round-robin from ptr=2 with channels 2 and 7.
      step_a(8'h84, MODE_RR, 3'd0, 1'b1, 8'h04);
      step_a(8'h84, MODE_RR, 3'd0, 1'b1, 8'h80);
      step_a(8'h84, MODE_RR, 3'd0, 1'b1, 8'h04);
      step_a(8'h84, MODE_RR, 3'd0, 1'b1, 8'h80);

      // Backpressure on a channel-3 beat; ptr (0) must survive the stall.
      step_a(8'hFF, MODE_FIXED, 3'd3, 1'b1, 8'h08);
      for (int i = 0; i < 4; i++) begin
         step_a(8'hFF, MODE_RR, 3'd0, 1'b0, 8'h00);
         chk("a_stall_valid", 64'(a_ovalid), 64'd1);
         chk("a_stall_data", 64'(a_odata), 64'hA000_0003);
         chk("a_stall_sel", 64'(a_osel), 64'd3);
      end
      step_a(8'hFF, MODE_RR, 3'd0, 1'b1, 8'h01);
      chk("a_nobubble_valid", 64'(a_ovalid), 64'd1);
      step_a(8'hFF, MODE_RR, 3'd0, 1'b1, 8'h02);

      // Reset during a stall drops the held beat and clears ptr (was 2).
      step_a(8'hFF, MODE_FIXED, 3'd4, 1'b1, 8'h10);
      step_a(8'hFF, MODE_FIXED, 3'd4, 1'b0, 8'h00);
      reset = 1'b1;
      @(negedge clk);
      chk("a_rststall_ack", 64'(a_ack), 64'd0);
      chk("a_rststall_hold", 64'(a_ovalid), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("a_rststall_valid", 64'(a_ovalid), 64'd0);
      qa.delete();
      step_a(8'hFF, MODE_RR, 3'd0, 1'b1, 8'h01);
      step_a(8'h00, MODE_RR, 3'd0, 1'b1, 8'h00);

      // Non-power-of-2 instance.
      a_valid = '0;
      reset = 1'b1;
      step_b(5'h1F, MODE_RR, 3'd0, 1'b1, 5'h00);
      reset = 1'b0;
      chk("b_rst_valid", 64'(b_ovalid), 64'd0);
      step_b(5'h1F, MODE_FIXED, 3'd6, 1'b1, 5'h00);
      chk("b_oor_valid", 64'(b_ovalid), 64'd0);
      step_b(5'h1F, MODE_FIXED, 3'd4, 1'b1, 5'h10);
      step_b(5'h1F, MODE_RR, 3'd0, 1'b1, 5'h01);
      step_b(5'h11, MODE_RR, 3'd0, 1'b1, 5'h10);
      step_b(5'h11, MODE_RR, 3'd0, 1'b1, 5'h01);
      step_b(5'h00, MODE_RR, 3'd0, 1'b1, 5'h00);
      chk("b_drain_valid", 64'(b_ovalid), 64'd0);

      chk("a_queue_empty", 64'(qa.size()), 64'd0);
      chk("b_queue_empty", 64'(qb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
